// File: rtl/ascon_pkg.sv
// Shared Ascon stream definitions: data_in type codes, mode codes,
// fixed segment length, request-sequencer state enum, word select helper.
package ascon_pkg;

  localparam logic [3:0] TYPE_EMPTY  = 4'd0;
  localparam logic [3:0] TYPE_KEY    = 4'd1;
  localparam logic [3:0] TYPE_NONCE  = 4'd2;
  localparam logic [3:0] TYPE_ASSOC  = 4'd3;
  localparam logic [3:0] TYPE_PLAIN  = 4'd4;
  localparam logic [3:0] TYPE_CIPHER = 4'd5;
  localparam logic [3:0] TYPE_TAG    = 4'd6;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  localparam int         SEG_WORDS = 4;
  localparam logic [1:0] SEG_LAST  = 2'(SEG_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_NONCE,
    ST_AD,
    ST_MSG,
    ST_TAG,
    ST_DONE
  } state_t;

  // Word i of a 128-bit value, most significant word first.
  function automatic logic [31:0] word_of(
    input logic [127:0] v,
    input logic [1:0]   i
  );
    logic [31:0] w;
    unique case (i)
      2'd0: w = v[127:96];
      2'd1: w = v[95:64];
      2'd2: w = v[63:32];
      2'd3: w = v[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ascon_stream_tx_if.sv
// Stream bundle: upstream word source (src_*) and core data_in (tx_*).
// master = transmitter side, slave = source/core side (or bench).
interface ascon_stream_tx_if;

  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_type;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    input  src_data, src_valid, tx_ready,
    output src_ready, tx_data, tx_type, tx_valid, tx_last
  );

  modport slave (
    output src_data, src_valid, tx_ready,
    input  src_ready, tx_data, tx_type, tx_valid, tx_last
  );

endinterface

// File: rtl/ascon_tx_outreg.sv
// One-entry output register for data/type/last; clk, rst (async low),
// load/flush in, ready in, valid/data/dtype/last out, can_load to FSM.
module ascon_tx_outreg
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_data,
  input  logic [3:0]  d_type,
  input  logic        d_last,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] data,
  output logic [3:0]  dtype,
  output logic        last,
  output logic        can_load
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      dtype <= TYPE_EMPTY;
      last  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
      dtype <= TYPE_EMPTY;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      dtype <= d_type;
      last  <= d_last;
    end else if (ready) begin
      // drained with nothing behind it: back to EMPTY
      valid <= 1'b0;
      data  <= '0;
      dtype <= TYPE_EMPTY;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ascon_stream_tx.sv
// Sequences one Ascon request (key, nonce, AD, msg, tag) onto data_in.
// Ports: start/mode/key/nonce/tag/lengths in, bus, busy/done; macro ASCON_STREAM_TX_ABORT_EN adds abort/aborted.
module ascon_stream_tx
  import ascon_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  ascon_stream_tx_if.master  bus,
  input  logic               start,
  input  logic               mode,
  input  logic [127:0]       key,
  input  logic [127:0]       nonce,
  input  logic [127:0]       tag,
  input  logic [LEN_W-1:0]   ad_len,
  input  logic [LEN_W-1:0]   msg_len,
  output logic               busy,
  output logic               done
`ifdef ASCON_STREAM_TX_ABORT_EN
  ,
  input  logic               abort,
  output logic               aborted
`endif
);

  state_t             state, state_n;
  logic [1:0]         idx;
  logic [LEN_W-1:0]   rem;
  logic               mode_r;
  logic [127:0]       key_r, nonce_r, tag_r;
  logic [LEN_W-1:0]   ad_len_r, msg_len_r;
  logic               ld, ld_last, can_load;
  logic [31:0]        ld_data;
  logic [3:0]         ld_type;
  logic               src_rdy, src_acc, kill;
  state_t             nxt_ad, nxt_msg, nxt_tag;

  assign busy          = (state != ST_IDLE);
  assign bus.src_ready = src_rdy;
  assign src_acc       = src_rdy && bus.src_valid;

`ifdef ASCON_STREAM_TX_ABORT_EN
  assign kill = abort && busy;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted <= 1'b0;
    else      aborted <= kill;
  end
`else
  assign kill = 1'b0;
`endif

  ascon_tx_outreg u_outreg (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .flush    (kill),
    .d_data   (ld_data),
    .d_type   (ld_type),
    .d_last   (ld_last),
    .ready    (bus.tx_ready),
    .valid    (bus.tx_valid),
    .data     (bus.tx_data),
    .dtype    (bus.tx_type),
    .last     (bus.tx_last),
    .can_load (can_load)
  );

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_data = '0;
    ld_type = TYPE_EMPTY;
    ld_last = 1'b0;
    src_rdy = 1'b0;
    done    = 1'b0;
    nxt_tag = (mode_r == MODE_DEC) ? ST_TAG : ST_DONE;
    nxt_msg = (msg_len_r != '0) ? ST_MSG : nxt_tag;
    nxt_ad  = (ad_len_r != '0) ? ST_AD : nxt_msg;
    unique case (state)
      ST_IDLE: begin
        // key word 0 comes straight from the input so it is
        // valid on the cycle after start
        if (start) begin
          ld      = 1'b1;
          ld_data = key[127:96];
          ld_type = TYPE_KEY;
          state_n = ST_KEY;
        end
      end
      ST_KEY, ST_NONCE, ST_TAG: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_last = (idx == SEG_LAST);
          if (state == ST_KEY) begin
            ld_data = word_of(key_r, idx);
            ld_type = TYPE_KEY;
            if (ld_last) state_n = ST_NONCE;
          end else if (state == ST_NONCE) begin
            ld_data = word_of(nonce_r, idx);
            ld_type = TYPE_NONCE;
            if (ld_last) state_n = nxt_ad;
          end else begin
            ld_data = word_of(tag_r, idx);
            ld_type = TYPE_TAG;
            if (ld_last) state_n = ST_DONE;
          end
        end
      end
      ST_AD, ST_MSG: begin
        src_rdy = (rem != '0) && can_load;
        if (src_acc) begin
          ld      = 1'b1;
          ld_data = bus.src_data;
          ld_last = (rem == LEN_W'(1));
          if (state == ST_AD) begin
            ld_type = TYPE_ASSOC;
            if (ld_last) state_n = nxt_msg;
          end else begin
            ld_type = (mode_r == MODE_ENC) ? TYPE_PLAIN : TYPE_CIPHER;
            if (ld_last) state_n = nxt_tag;
          end
        end
      end
      ST_DONE: begin
        // final word has left the output register
        if (!bus.tx_valid) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (kill) begin
      state_n = ST_IDLE;
      ld      = 1'b0;
      src_rdy = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      if (kill)
        idx <= '0;
      else if (ld && (state inside {ST_IDLE, ST_KEY, ST_NONCE, ST_TAG}))
        idx <= idx + 2'd1;
      if (kill)
        rem <= '0;
      else if (state_n != state)
        rem <= (state_n == ST_AD)  ? ad_len_r  :
               (state_n == ST_MSG) ? msg_len_r : '0;
      else if (src_acc && rem != '0)
        rem <= rem - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= MODE_DEC;
      key_r     <= '0;
      nonce_r   <= '0;
      tag_r     <= '0;
      ad_len_r  <= '0;
      msg_len_r <= '0;
    end else if (state == ST_IDLE && start) begin
      mode_r    <= mode;
      key_r     <= key;
      nonce_r   <= nonce;
      tag_r     <= tag;
      ad_len_r  <= ad_len;
      msg_len_r <= msg_len;
    end
  end

endmodule

// File: tb/tb_ascon_stream_tx.sv
// Directed bench for ascon_stream_tx with an expected-word scoreboard.
// Abort scenario runs when ASCON_STREAM_TX_ABORT_EN is defined.
module tb_ascon_stream_tx;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] key = '0, nonce = '0, tag = '0;
  logic [7:0]   ad_len = '0, msg_len = '0;
  logic         busy, done;
  logic         ab_now;
`ifdef ASCON_STREAM_TX_ABORT_EN
  logic         abort = 1'b0;
  logic         aborted;
  assign ab_now = aborted;
`else
  assign ab_now = 1'b0;
`endif

  ascon_stream_tx_if bus ();

  ascon_stream_tx #(.LEN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .start   (start),
    .mode    (mode),
    .key     (key),
    .nonce   (nonce),
    .tag     (tag),
    .ad_len  (ad_len),
    .msg_len (msg_len),
    .busy    (busy),
    .done    (done)
`ifdef ASCON_STREAM_TX_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [36:0] exp_q[$];
  logic [31:0] src_q[$];
  int  ready_mode = 0;
  int  gap_left = 0;
  bit  pend_pop = 0;
  int  ncyc = 0;
  int  req_xfers, first_xfer, last_xfer;
  int  src_acc_cnt, gap_cnt, n_assoc, done_cnt = 0;
  logic [31:0] first_data;
  bit  hold_v = 0;
  logic [36:0] hold_w;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Observe on the falling edge; a transfer seen here happens on the
  // next rising edge, and the values are stable until then.
  always @(negedge clk) begin
    logic [36:0] w;
    if (rst) begin
      ncyc++;
      if (hold_v && !ab_now)
        chk("stall_hold", {bus.tx_valid, bus.tx_type, bus.tx_data, bus.tx_last},
            {1'b1, hold_w});
      hold_v = bus.tx_valid && !bus.tx_ready;
      hold_w = {bus.tx_type, bus.tx_data, bus.tx_last};
      if (!bus.tx_valid) chk("empty_type", bus.tx_type, TYPE_EMPTY);
      if (busy && !bus.tx_valid && !done) gap_cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("xfer_word", {bus.tx_type, bus.tx_data, bus.tx_last}, w);
        end
        if (req_xfers == 0) begin
          first_data = bus.tx_data;
          first_xfer = ncyc;
        end
        req_xfers++;
        last_xfer = ncyc;
        if (bus.tx_type == TYPE_ASSOC) n_assoc++;
      end
      if (bus.src_valid && bus.src_ready) begin
        src_acc_cnt++;
        pend_pop = 1;
      end
      if (done) begin
        done_cnt++;
        chk("done_q_empty", exp_q.size(), 0);
        chk("done_timing", last_xfer, ncyc - 1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pend_pop) begin
      void'(src_q.pop_front());
      pend_pop = 0;
    end
    case (ready_mode)
      0: bus.tx_ready = 1'b1;
      1: bus.tx_ready = ($urandom_range(0, 9) < 3);
      default: bus.tx_ready = 1'b0;
    endcase
    if (gap_left > 0 && src_acc_cnt >= 1) begin
      bus.src_valid = 1'b0;
      gap_left--;
    end else begin
      bus.src_valid = (src_q.size() > 0);
    end
    bus.src_data = (src_q.size() > 0) ? src_q[0] : 32'h0;
  endtask

  task automatic begin_req(input logic m, input int adl, input int ml,
                           input int gap);
    logic [31:0] w;
    req_xfers = 0; src_acc_cnt = 0; gap_cnt = 0; n_assoc = 0;
    gap_left = gap;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({TYPE_KEY, key[127-32*i -: 32], i == 3});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({TYPE_NONCE, nonce[127-32*i -: 32], i == 3});
    for (int i = 0; i < adl; i++) begin
      w = $urandom;
      src_q.push_back(w);
      exp_q.push_back({TYPE_ASSOC, w, i == adl - 1});
    end
    for (int i = 0; i < ml; i++) begin
      w = $urandom;
      src_q.push_back(w);
      exp_q.push_back({m ? TYPE_PLAIN : TYPE_CIPHER, w, i == ml - 1});
    end
    if (!m)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({TYPE_TAG, tag[127-32*i -: 32], i == 3});
    mode = m; ad_len = 8'(adl); msg_len = 8'(ml);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("first_key_valid", bus.tx_valid, 1);
    key = ~key; nonce = ~nonce; tag = ~tag;
    mode = ~m; ad_len = ~ad_len; msg_len = ~msg_len;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin
      cyc();
      n++;
    end
    chk({nm, "_done_seen"}, done_cnt - d0, 1);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
    chk({nm, "_src_empty"}, src_q.size(), 0);
  endtask

  initial begin
    bus.tx_ready = 1'b0; bus.src_valid = 1'b0; bus.src_data = '0;
    #12;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_last", bus.tx_last, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_type", bus.tx_type, TYPE_EMPTY);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #1 rst = 1'b1;
    cyc();

    // encrypt, AD 2, msg 3, tx_ready held high
    key = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    nonce = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    tag = '0;
    ready_mode = 0;
    begin_req(MODE_ENC, 2, 3, 0);
    wait_done("enc");
    chk("enc_xfers", req_xfers, 13);
    chk("enc_back_to_back", last_xfer - first_xfer, 12);
    chk("enc_first_data", first_data, 32'h00010203);
    chk("enc_no_gap", gap_cnt, 0);

    // decrypt, no AD, one message word, tag
    key = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    nonce = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    tag = 128'hAABBCCDD_11223344_55667788_99AABBCC;
    begin_req(MODE_DEC, 0, 1, 0);
    wait_done("dec");
    chk("dec_xfers", req_xfers, 13);
    chk("dec_no_assoc", n_assoc, 0);

    // encrypt, msg 5, tx_ready at about 30 percent
    key = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    nonce = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;
    ready_mode = 1;
    begin_req(MODE_ENC, 0, 5, 0);
    wait_done("rnd");
    chk("rnd_xfers", req_xfers, 13);
    chk("rnd_src_accepts", src_acc_cnt, 5);
    ready_mode = 0;

    // source gap of 3 cycles after the first AD word
    key = 128'h11111111_22222222_33333333_44444444;
    nonce = 128'h99999999_88888888_77777777_66666666;
    begin_req(MODE_ENC, 3, 2, 3);
    wait_done("gap");
    chk("gap_cycles", gap_cnt, 3);
    chk("gap_assoc", n_assoc, 3);
    chk("gap_src_accepts", src_acc_cnt, 5);

    // asynchronous reset while the 2nd nonce word is held
    key = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    nonce = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
    begin_req(MODE_ENC, 1, 1, 0);
    begin
      int n = 0;
      while (req_xfers < 5 && n < 100) begin
        cyc();
        n++;
      end
      chk("rst_reach_nonce2", req_xfers, 5);
    end
    #1 rst = 1'b0;
    #1;
    chk("arst_tx_valid", bus.tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_type", bus.tx_type, TYPE_EMPTY);
    #1 rst = 1'b1;
    exp_q.delete(); src_q.delete(); pend_pop = 0; hold_v = 0;
    cyc();
    chk("arst_stays_idle", busy, 0);
    key = 128'hCAFEBABE_00000001_00000002_00000003;
    nonce = 128'hFEEDFACE_10000000_20000000_30000000;
    begin_req(MODE_ENC, 1, 1, 0);
    wait_done("replay");
    chk("replay_xfers", req_xfers, 10);

`ifdef ASCON_STREAM_TX_ABORT_EN
    // abort in MSG while tx_ready is low
    key = 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D;
    nonce = 128'h01010101_02020202_03030303_04040404;
    begin_req(MODE_ENC, 0, 4, 0);
    begin
      int n = 0;
      int d0 = done_cnt;
      while (req_xfers < 9 && n < 100) begin
        cyc();
        n++;
      end
      chk("ab_reach_msg", req_xfers, 9);
      ready_mode = 2;
      bus.tx_ready = 1'b0;
      cyc();
      chk("ab_held_valid", bus.tx_valid, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("ab_tx_valid", bus.tx_valid, 0);
      chk("ab_aborted", aborted, 1);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      cyc();
      chk("ab_pulse_end", aborted, 0);
      cyc();
      chk("ab_no_done", done_cnt - d0, 0);
    end
    exp_q.delete(); src_q.delete(); pend_pop = 0; hold_v = 0;
    ready_mode = 0;
    begin_req(MODE_DEC, 1, 1, 0);
    wait_done("after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
